kernel_launcher: RTL and testbench
==================================

// Module: kernel_launcher
// PURPOSE
//  Job scheduler in front of one synthesized kernel core (start/init/done/result interface).
//  Buffers incoming jobs (init value + tag) in a FIFO and launches them one at a time.
//  Waits for done, with a cycle timeout, and returns each result on a valid/ready output
//  stream. Sits between the host-side job stream and the kernel instance.
// PARAMETERS
//  DATA_W     64   width of job init value and kernel result
//  TAG_W      4    width of job tag, returned unchanged with the result
//  DEPTH      4    job FIFO entries (power of 2, >=2)
//  TIMEOUT    255  max RUN cycles before abort (1..2^16-1)
// PORTS
//  clk        in   1        clock, all logic on posedge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        job offered
//  in_ready   out  1        FIFO can accept (= !full)
//  in_data    in   DATA_W   job init value
//  in_tag     in   TAG_W    job tag
//  out_valid  out  1        result held for consumer
//  out_ready  in   1        consumer accepts result
//  out_data   out  DATA_W   kernel result (0 on timeout)
//  out_tag    out  TAG_W    tag of the finished job
//  out_err    out  1        1 = job aborted by timeout
//  k_start    out  1        kernel start pulse (drives kernel r_enable)
//  k_init     out  DATA_W   kernel init value (valid while k_start=1)
//  k_done     in   1        kernel done level (kernel w_enable; stays 1 until next start)
//  k_result   in   DATA_W   kernel result, valid while k_done=1
//  busy       out  1        FSM not IDLE or FIFO non-empty
//  done_cnt   out  16       jobs completed (ok or error), wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (rst_n=0, async): FSM=IDLE, FIFO empty, all outputs 0, done_cnt=0; in_ready=1 after release.
//  FIFO: push when in_valid&&in_ready; in_ready=!full from registered count; no push while
//   full even if a pop occurs the same cycle. Pop only on IDLE->LAUNCH.
//  FSM states IDLE, LAUNCH, RUN, OUT:
//   IDLE:   FIFO non-empty -> pop head into job regs -> LAUNCH next cycle.
//   LAUNCH: k_start=1 and k_init=job data for exactly one cycle; timer cleared -> RUN.
//   RUN:    k_done ignored in first RUN cycle (kernel clears done at start edge).
//           From second RUN cycle: k_done=1 -> capture k_result, out_err=0 -> OUT.
//           Timer increments every RUN cycle; timer==TIMEOUT with no done -> out_data=0,
//           out_err=1 -> OUT. done and timeout in same cycle: done wins.
//   OUT:    out_valid=1, out_data/out_tag/out_err stable until out_ready.
//           out_valid&&out_ready -> done_cnt+1; FIFO non-empty -> pop, LAUNCH next cycle
//           (no IDLE bubble), else IDLE.
//  Aborted kernel is not reset separately; next LAUNCH start pulse reinitialises it.
//  Min per-job latency: push -> out_valid = 1 (IDLE) + 1 (LAUNCH) + kernel latency + 1.
//  k_init holds last job value outside LAUNCH; k_start is never high two consecutive cycles.
//  Results leave in FIFO order; only one job in flight.
//  Reset mid-job: everything returns to reset values immediately; in-flight job lost.
// TESTING
//  Kernel model: done 8 cycles after start, result = 2 for even init, 3 for odd; hangs if init=0xDEAD.
//  1 job init=4 tag=1, out_ready=1 -> one k_start pulse, out_data=2 tag=1 err=0, done_cnt=1.
//  Push 5 jobs back-to-back, out_ready=1 -> 5th accepted only after first pop (in_ready=0
//   with 4 queued); results 2/3 alternating in tag order; done_cnt=5.
//  init=0xDEAD, TIMEOUT=20 -> out_valid after 20 RUN cycles, out_data=0, out_err=1; next job init=7 -> 3, err=0.
//  out_ready=0 for 30 cycles during OUT -> outputs stable, no new k_start; release -> next launch next cycle.
//  Drop rst_n mid-RUN -> all outputs 0 asynchronously, FIFO empty; fresh job after release returns correctly.
//  Preload done_cnt to 0xFFFF via 65535 jobs (or force) -> one more job wraps done_cnt to 0.

Source files
------------

// File: rtl/kernel_launcher.sv
// Job scheduler in front of a single kernel core: queues jobs (init value + tag),
// launches them one at a time, waits for done with a timeout, and hands the result
// (or a timeout error) to a valid/ready output stream.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | nothing in flight; pops the FIFO head when one is available
// S_LAUNCH | one-cycle k_start pulse carrying the job's init value
// S_RUN    | waiting for k_done; aborts after TIMEOUT RUN cycles
// S_OUT    | result held on the output stream until out_ready
module kernel_launcher #(
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic              k_start,
  output logic [DATA_W-1:0] k_init,
  input  logic              k_done,
  input  logic [DATA_W-1:0] k_result,
  output logic              busy,
  output logic [15:0]       done_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_OUT} state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [TAG_W-1:0]  fifo_tag  [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_next;

  logic [DATA_W-1:0] job_data;
  logic [TAG_W-1:0]  job_tag;
  logic [15:0]       timer;
  logic              ready_q;

  logic push, pop, capture_ok, capture_err, fifo_nonempty;

  assign fifo_nonempty = (count != '0);
  // in_ready is registered so it reads 0 while reset is asserted
  assign in_ready      = ready_q;
  assign push          = in_valid && ready_q;
  assign count_next    = count + CW'(push) - CW'(pop);

  assign k_start   = (state == S_LAUNCH);
  assign k_init    = job_data;
  assign out_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE) || fifo_nonempty;

  // Next-state logic; pops happen on IDLE->LAUNCH and OUT->LAUNCH only
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    capture_ok  = 1'b0;
    capture_err = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fifo_nonempty) begin
          pop        = 1'b1;
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: state_next = S_RUN;
      S_RUN: begin
        // timer==0 is the first RUN cycle, where k_done may still be stale
        if (k_done && (timer != '0)) begin
          capture_ok = 1'b1;
          state_next = S_OUT;
        end else if (timer == TMO_LAST) begin
          capture_err = 1'b1;
          state_next  = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (fifo_nonempty) begin
            pop        = 1'b1;
            state_next = S_LAUNCH;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= in_data;
      fifo_tag[wr_ptr]  <= in_tag;
    end
  end

  // FSM, FIFO bookkeeping, job/result registers and completion counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_q  <= 1'b0;
      job_data <= '0;
      job_tag  <= '0;
      timer    <= '0;
      out_data <= '0;
      out_tag  <= '0;
      out_err  <= 1'b0;
      done_cnt <= '0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      ready_q <= (count_next != CW'(DEPTH));
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        job_data <= fifo_data[rd_ptr];
        job_tag  <= fifo_tag[rd_ptr];
      end
      if (state == S_LAUNCH) timer <= '0;
      else if (state == S_RUN) timer <= timer + 1'b1;
      if (capture_ok) begin
        out_data <= k_result;
        out_tag  <= job_tag;
        out_err  <= 1'b0;
      end else if (capture_err) begin
        out_data <= '0;
        out_tag  <= job_tag;
        out_err  <= 1'b1;
      end
      if ((state == S_OUT) && out_ready) done_cnt <= done_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_kernel_launcher.sv
// Bench for kernel_launcher: behavioural kernel model, queue-based result
// model, directed scenarios followed by a randomized job/back-pressure phase.
module tb_kernel_launcher;

  localparam logic [63:0] DEAD = 64'hDEAD;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [63:0] in_data;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_tag;
  logic        out_err;
  logic        k_start;
  logic [63:0] k_init;
  logic        k_done;
  logic [63:0] k_result;
  logic        busy;
  logic [15:0] done_cnt;

  kernel_launcher #(.DATA_W(64), .TAG_W(4), .DEPTH(4), .TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err),
    .k_start(k_start), .k_init(k_init), .k_done(k_done), .k_result(k_result),
    .busy(busy), .done_cnt(done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Kernel model: done 8 edges after the start edge, result 2 (even) / 3 (odd),
  // never finishes for init 0xDEAD. Done clears one edge after start, so it is
  // stale during the first RUN cycle.
  logic        k_pend;
  logic [63:0] k_latched;
  int          k_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_pend <= 1'b0; k_latched <= '0; k_cnt <= 0; k_done <= 1'b0; k_result <= '0;
    end else begin
      k_pend <= k_start;
      if (k_start) k_latched <= k_init;
      if (k_pend) begin
        k_done <= 1'b0;
        k_cnt  <= (k_latched == DEAD) ? 0 : 7;
      end else if (k_cnt > 0) begin
        k_cnt <= k_cnt - 1;
        if (k_cnt == 1) begin
          k_done   <= 1'b1;
          k_result <= k_latched[0] ? 64'd3 : 64'd2;
        end
      end
    end
  end

  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_cnt = '0;
  int          kstart_cnt = 0;
  logic        prev_k = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] hold_data;
  logic [4:0]  hold_meta;

  // Output monitor: samples mid-low-phase, after drivers have settled
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) begin
      prev_k = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (k_start) begin
        kstart_cnt++;
        check("kstart_gap", {95'd0, prev_k}, 96'd0);
      end
      prev_k = k_start;
      if (prev_stall) begin
        check("hold_data", {32'd0, out_data}, {32'd0, hold_data});
        check("hold_meta", {91'd0, out_tag, out_err}, {91'd0, hold_meta});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 96'd1, 96'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {32'd0, out_data}, {32'd0, e.data});
          check("out_tag",  {92'd0, out_tag},  {92'd0, e.tag});
          check("out_err",  {95'd0, out_err},  {95'd0, e.err});
        end
        check("done_cnt", {80'd0, done_cnt}, {80'd0, exp_cnt});
        exp_cnt = exp_cnt + 16'd1;
      end
      prev_stall = out_valid && !out_ready;
      hold_data  = out_data;
      hold_meta  = {out_tag, out_err};
    end
  end

  // Offer one job starting at a negedge; records the expected result when accepted
  task automatic push_job(input logic [63:0] d, input logic [3:0] t);
    int   n;
    exp_t e;
    in_valid = 1'b1; in_data = d; in_tag = t; n = 0;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("push_timeout", 96'd0, 96'd1);
    end else begin
      e.tag = t;
      if (d == DEAD) begin e.data = '0; e.err = 1'b1; end
      else begin e.data = d[0] ? 64'd3 : 64'd2; e.err = 1'b0; end
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_busy", {95'd0, busy}, 96'd0);
    check("idle_queue", 96'(exp_q.size()), 96'd0);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", {95'd0, out_valid}, 96'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, ks0;
    logic [63:0] d0;
    logic [4:0]  m0;
    logic        stable;
    logic        rand_done;
    logic [15:0] cnt0;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;
    #3;
    check("rst_out_valid", {95'd0, out_valid}, 96'd0);
    check("rst_in_ready",  {95'd0, in_ready},  96'd0);
    check("rst_k_start",   {95'd0, k_start},   96'd0);
    check("rst_busy",      {95'd0, busy},      96'd0);
    check("rst_done_cnt",  {80'd0, done_cnt},  96'd0);
    check("rst_k_init",    {32'd0, k_init},    96'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {95'd0, in_ready}, 96'd1);

    // Single job
    out_ready = 1'b1;
    ks0 = kstart_cnt;
    push_job(64'd4, 4'd1);
    wait_idle();
    check("single_kstarts", 96'(kstart_cnt - ks0), 96'd1);
    check("single_done_cnt", {80'd0, done_cnt}, 96'd1);

    // Five jobs back-to-back: FIFO fills behind the first in-flight job
    cnt0 = done_cnt;
    for (int i = 0; i < 5; i++) push_job(64'(10 + i), 4'(i));
    check("full_in_ready", {95'd0, in_ready}, 96'd0);
    check("full_busy", {95'd0, busy}, 96'd1);
    wait_idle();
    check("burst_done_cnt", {80'd0, done_cnt}, {80'd0, cnt0 + 16'd5});

    // Timeout: hung kernel aborts after exactly 20 RUN cycles
    n = 0;
    push_job(DEAD, 4'd9);
    while (!k_start && n < 20) begin @(negedge clk); n++; end
    check("tmo_launch", {95'd0, k_start}, 96'd1);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    check("tmo_latency", 96'(n), 96'd21);
    check("tmo_err", {95'd0, out_err}, 96'd1);
    wait_idle();
    push_job(64'd7, 4'd10);
    wait_idle();

    // Back-pressure: result held 30 cycles, no launch until release
    out_ready = 1'b0;
    push_job(64'd6, 4'd3);
    push_job(64'd9, 4'd4);
    wait_out(n);
    d0 = out_data; m0 = {out_tag, out_err}; ks0 = kstart_cnt; stable = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (!out_valid || out_data != d0 || {out_tag, out_err} != m0 || k_start) stable = 1'b0;
    end
    check("stall_stable", {95'd0, stable}, 96'd1);
    check("stall_no_start", 96'(kstart_cnt - ks0), 96'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("release_launch", {95'd0, k_start}, 96'd1);
    wait_idle();

    // Asynchronous reset during RUN
    push_job(64'd10, 4'd2);
    n = 0;
    while (!k_start && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {95'd0, out_valid}, 96'd0);
    check("arst_k_start",   {95'd0, k_start},   96'd0);
    check("arst_busy",      {95'd0, busy},      96'd0);
    check("arst_in_ready",  {95'd0, in_ready},  96'd0);
    check("arst_done_cnt",  {80'd0, done_cnt},  96'd0);
    check("arst_k_init",    {32'd0, k_init},    96'd0);
    check("arst_out_data",  {32'd0, out_data},  96'd0);
    exp_q.delete();
    exp_cnt = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_job(64'd13, 4'd5);
    wait_idle();
    check("post_rst_done_cnt", {80'd0, done_cnt}, 96'd1);

    // Randomized jobs with random back-pressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [63:0] d;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          d = ($urandom_range(0, 5) == 0) ? DEAD : {$urandom, $urandom};
          push_job(d, 4'($urandom_range(0, 15)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_idle();

    // Counter wrap 0xFFFF -> 0
    force dut.done_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.done_cnt;
    check("preload_cnt", {80'd0, done_cnt}, 96'hFFFF);
    exp_cnt = 16'hFFFF;
    push_job(64'd20, 4'd7);
    wait_idle();
    check("wrap_cnt", {80'd0, done_cnt}, 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
